// File: rtl/trace_pkg.sv
// Shared record and history-entry types for the commit trace port.
package trace_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned TRACE_SEQ_W = 16;

    typedef struct packed {
        logic [PC_W-1:0]        pc;
        logic [PC_W-1:0]        inst;
        logic [TRACE_SEQ_W-1:0] seq;
    } trace_rec_t;

    typedef struct packed {
        logic            v;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] inst;
    } hist_ent_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a registered head word; push and pop may coincide,
// including when full.
module trace_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned W     = 80,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          head_valid,
    output logic [CW-1:0] count_next,
    output logic          drop
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count;
    logic [CW-1:0] remain;
    logic [W-1:0]  head_next;
    logic          full;
    logic          pop_ok;
    logic          push_ok;

    always_comb begin
        full        = (count == CW'(DEPTH));
        pop_ok      = pop && (count != '0);
        push_ok     = push && (!full || pop_ok);
        drop        = push && !push_ok;
        remain      = count - CW'(pop_ok);
        count_next  = remain + CW'(push_ok);
        rd_ptr_next = rd_ptr + AW'(pop_ok);
        // An entry written this edge only becomes head when nothing older remains.
        head_next   = (remain == '0) ? push_data : mem[rd_ptr_next];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            head_valid <= (count_next != '0);
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (count_next != '0) begin
                head <= head_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/commit_trace_port.sv
// Delays each new fetch through a history pipe and streams retire records
// to an external reader, stalling the CPU before the buffer fills.
module commit_trace_port
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HIST        = 5,
    parameter int unsigned STALL_SLACK = 2,
    parameter int unsigned MAX_RECORDS = 5000,
    parameter int unsigned SEQ_W       = TRACE_SEQ_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  inst,
    output logic             cpu_stall,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [PC_W-1:0]  trace_pc,
    output logic [PC_W-1:0]  trace_inst,
    output logic [SEQ_W-1:0] trace_seq,
    output logic             done,
    output logic             overflow
);

    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned RW    = 2 * PC_W + SEQ_W;
    localparam int unsigned CNT_W = 32;

    logic [PC_W-1:0]  last_pc;
    hist_ent_t        hist [HIST];
    hist_ent_t        fetch_ent;
    hist_ent_t        cand;
    logic             chg;
    logic             push;
    logic [CNT_W-1:0] rec_cnt;
    logic [RW-1:0]    rec_data;
    logic [RW-1:0]    head;
    logic [CW-1:0]    count_next;
    logic             drop;

    assign fetch_ent = '{v: 1'b1, pc: pc, inst: inst};

    // The candidate is whatever lands in the last history stage on this shift.
    if (HIST == 1) begin : g_hist_one
        assign cand = fetch_ent;
    end else begin : g_hist_many
        assign cand = hist[HIST-2];
    end

    always_comb begin
        chg      = (pc != last_pc);
        push     = chg && cand.v && !done;
        rec_data = {cand.pc, cand.inst, rec_cnt[SEQ_W-1:0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_pc   <= '0;
            rec_cnt   <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            cpu_stall <= 1'b0;
            for (int unsigned i = 0; i < HIST; i++) begin
                hist[i] <= '0;
            end
        end else begin
            if (chg) begin
                last_pc <= pc;
                hist[0] <= fetch_ent;
                for (int unsigned i = 1; i < HIST; i++) begin
                    hist[i] <= hist[i-1];
                end
            end
            // Dropped records still consume a sequence number so the gap is visible.
            if (push) begin
                rec_cnt <= rec_cnt + CNT_W'(1);
                if (rec_cnt + CNT_W'(1) == CNT_W'(MAX_RECORDS)) begin
                    done <= 1'b1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            cpu_stall <= (count_next >= CW'(DEPTH - STALL_SLACK));
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push       (push),
        .push_data  (rec_data),
        .pop        (trace_valid && trace_ready),
        .head       (head),
        .head_valid (trace_valid),
        .count_next (count_next),
        .drop       (drop)
    );

    assign trace_pc   = head[RW-1 -: PC_W];
    assign trace_inst = head[SEQ_W +: PC_W];
    assign trace_seq  = head[SEQ_W-1:0];

endmodule

// File: doc/commit_trace_port.md
Name: commit_trace_port

Overview:
- Hardware counterpart of the bench-side commit tracer. Sits beside the pipeline top, watches the fetch-stage `pc`/`inst`, and delays each new fetch through a HIST-deep history so a record is emitted only once the instruction has left the pipeline.
- Buffers the (pc, inst, seq) retire records in a FIFO and drains them to an external trace reader over a valid/ready handshake.
- Drives `cpu_stall` back into the CPU when the FIFO nears full, so no record is lost.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 4.
- HIST, 5: history stages between capture and emit; at least 1.
- STALL_SLACK, 2: `cpu_stall` asserts when FIFO count ≥ DEPTH−STALL_SLACK.
- MAX_RECORDS, 5000: records accepted before `done`.
- SEQ_W, 16: width of the sequence number.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low.
- pc, input, 32: current fetch PC from the CPU.
- inst, input, 32: instruction at `pc`.
- cpu_stall, output, 1: stall request to the CPU, registered.
- trace_valid, output, 1: a record is presented.
- trace_ready, input, 1: the reader accepts the record.
- trace_pc, output, 32: record PC.
- trace_inst, output, 32: record instruction.
- trace_seq, output, SEQ_W: record index, starting at 0.
- done, output, 1: MAX_RECORDS records have been pushed; sticky.
- overflow, output, 1: a push was dropped because the FIFO was full; sticky.

Behaviour:
- Reset (reset=0), asynchronous:
  - all history valid bits cleared; last_pc = 0.
  - FIFO empty; pushed-record counter = 0.
  - Outputs: `cpu_stall`=0, `trace_valid`=0, `trace_pc`=0, `trace_inst`=0, `trace_seq`=0, `done`=0, `overflow`=0.
- Change detect: `chg` = (pc != last_pc). On `chg`, last_pc <= pc. A stalled CPU holds `pc`, so there is no `chg`.
- History shift on `chg`:
  - hist[0] <= {1, pc, inst}; hist[i] <= hist[i-1].
  - The entry shifted into hist[HIST-1] is the emit candidate.
  - Push iff candidate valid and not `done`.
  - With HIST=5, the first push happens on the 5th PC change after reset.
- Push: record = {candidate pc, candidate inst, seq = pushed counter}; the counter then increments.
  - Counter reaching MAX_RECORDS sets `done` in the same edge.
  - Afterwards history keeps shifting, but nothing is pushed.
- Latency: a pushed record is visible at the FIFO head no earlier than the next cycle. `trace_*` are registered FIFO outputs.
- Handshake:
  - A pop occurs when `trace_valid` && `trace_ready`.
  - While `trace_valid`=1 and `trace_ready`=0, `trace_pc`/`trace_inst`/`trace_seq` hold stable.
  - `trace_valid` never drops without a pop, except on reset.
- Simultaneous push and pop:
  - Always allowed, including at full; count unchanged.
  - Empty + push + no pop: count becomes 1, `trace_valid` rises the next cycle.
- Full:
  - Push with no pop drops the record; `overflow` <= 1 (sticky until reset).
  - The counter still increments, so a gap in `trace_seq` marks the loss.
- Stall: `cpu_stall` <= (count_next ≥ DEPTH−STALL_SLACK); deasserts when count_next drops below the threshold.
- Pointers: wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- Reset mid-operation: any buffered records and history are discarded; `trace_seq` restarts at 0.

Decomposition:
- Shared package `trace_pkg`:
  - `trace_rec_t` struct {pc[31:0], inst[31:0], seq[SEQ_W-1:0]}.
  - `hist_ent_t` struct {v, pc, inst}.
  - Constant PC_W=32.
- One sub-module: `trace_fifo`, a synchronous FIFO with registered head, count output, and simultaneous-push/pop support.
- History, change detect, counters and stall logic live in `commit_trace_port`.

Test Plan:
1. Reset released; pc steps 0x00400000, 0x00400004, …, one new PC per cycle; trace_ready=1 → first trace_valid carries pc=0x00400000, seq=0, after the 5th change; following records have consecutive seq with pc stepping by +4.
2. pc held at 0x00400008 for 10 cycles → no new pushes; the FIFO drains; trace_valid=0 once empty.
3. trace_ready=0 with continuous pc changes, DEPTH=8 → cpu_stall=1 when count reaches 6; bench freezes pc on stall; no overflow; after trace_ready=1, records seq 0..7 arrive in order with no gap.
4. trace_ready=0 and pc kept changing despite stall → 9th push is dropped; overflow=1; after drain, the seq jump from 7 to 9 is observed.
5. MAX_RECORDS=3, trace_ready=1 → exactly seq 0,1,2 delivered; done=1 after the 3rd push; no further records despite 20 more PC changes.
6. reset asserted while 4 records are buffered and trace_ready=0 → outputs go to 0 immediately (asynchronously); after release, the first record has seq=0.
